vec_dist_pipe: RTL and testbench

//  Sequential, parametrised vector-distance engine for the coprocessor datapath.

---
 rtl/dist_pkg.sv | 23 ++
 rtl/reduce_tree_pipe.sv | 67 ++++++
 rtl/vec_dist_pipe.sv | 145 ++++++++++++++
 tb/tb_vec_dist_pipe.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
// Shared opcodes, state/mode types and opcode decode for the vector-distance engine.
// Opcode 104 (Chebyshev) is only decoded when DIST_MAX_MODE_EN is defined.
package dist_pkg;

  localparam logic [7:0] OP_MAN_DIST = 8'd103;
  localparam logic [7:0] OP_MAX_DIST = 8'd104;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dist_state_t;
  typedef enum logic {MODE_SUM, MODE_MAX} dist_mode_t;

  function automatic logic op_supported(input logic [7:0] op);
`ifdef DIST_MAX_MODE_EN
    return (op == OP_MAN_DIST) || (op == OP_MAX_DIST);
`else
    return op == OP_MAN_DIST;
`endif
  endfunction

  function automatic dist_mode_t op_mode(input logic [7:0] op);
    return (op == OP_MAX_DIST) ? MODE_MAX : MODE_SUM;
  endfunction

endpackage

// File: rtl/reduce_tree_pipe.sv
// Registered LANES-input reduction tree (sum, or max when DIST_MAX_MODE_EN is defined)
// with a valid tag travelling alongside; latency is $clog2(LANES) cycles.
module reduce_tree_pipe
  import dist_pkg::*;
#(
  parameter int LANES = 64,
  parameter int IN_W  = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  dist_mode_t                         i_mode,
  input  logic                               i_vld,
  input  logic [LANES-1:0][IN_W-1:0]         i_data,
  output logic                               o_vld,
  output logic [IN_W+$clog2(LANES)-1:0]      o_data
);

  localparam int TREE  = $clog2(LANES);
  localparam int OUT_W = IN_W + TREE;

  // Heap-indexed nodes: 1 is the root, LANES..2*LANES-1 are the leaves.
  logic [2*LANES-1:1][OUT_W-1:0] w_node;
  logic [TREE-1:0]               r_vld;

  for (genvar i = 0; i < LANES; i++) begin : g_leaf
    assign w_node[LANES+i] = OUT_W'(i_data[i]);
  end

  // Each node register is only as wide as its level needs: one bit more than its children.
  for (genvar n = 1; n < LANES; n++) begin : g_node
    localparam int DEPTH  = $clog2(n + 1) - 1;
    localparam int NODE_W = IN_W + TREE - DEPTH;
    logic [NODE_W-1:0] r_val;

    always_ff @(posedge clk) begin
      if (rst)
        r_val <= '0;
`ifdef DIST_MAX_MODE_EN
      else if (i_mode == MODE_MAX)
        r_val <= NODE_W'((w_node[2*n] > w_node[2*n+1]) ? w_node[2*n] : w_node[2*n+1]);
`endif
      else
        r_val <= NODE_W'(w_node[2*n] + w_node[2*n+1]);
    end

    assign w_node[n] = OUT_W'(r_val);
  end

`ifndef DIST_MAX_MODE_EN
  logic w_unused_mode;
  assign w_unused_mode = i_mode;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_vld;
      for (int k = 1; k < TREE; k++)
        r_vld[k] <= r_vld[k-1];
    end
  end

  assign o_vld  = r_vld[TREE-1];
  assign o_data = w_node[1];

endmodule

// File: rtl/vec_dist_pipe.sv
// Chunked Manhattan-distance engine: abs-diff stage, registered reduction tree, accumulator.
// Defining DIST_MAX_MODE_EN adds the Chebyshev (max) opcode.
//
//   state | meaning
//   IDLE  | after reset, waiting for a supported start
//   RUN   | streaming chunk r_idx into the pipe, one per cycle
//   DRAIN | pipe emptying into the accumulator
//   DONE  | result valid, waiting for the next start
module vec_dist_pipe
  import dist_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 1024,
  parameter int LANES  = 64
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [LENGTH-1:0][WIDTH-1:0]                  out_a,
  input  logic [LENGTH-1:0][WIDTH-1:0]                  out_b,
  input  logic [7:0]                                    op,
  input  logic                                          start,
  output logic                                          busy,
  output logic                                          calc_ready,
  output logic [WIDTH+$clog2(LENGTH)-1:0]               result,
  output logic [(WIDTH+$clog2(LENGTH)+7)/8-1:0][7:0]    aux_result
);

  localparam int CHUNKS = LENGTH / LANES;
  localparam int TREE   = $clog2(LANES);
  localparam int RES_W  = WIDTH + $clog2(LENGTH);
  localparam int NBYTES = (RES_W + 7) / 8;
  localparam int AUX_W  = NBYTES * 8;
  localparam int TREE_W = WIDTH + TREE;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int DCNT_W = $clog2(TREE + 2);
  localparam logic [DCNT_W-1:0] DRAIN_LEN = DCNT_W'(TREE + 1);

  dist_state_t r_state, w_state_nxt;
  dist_mode_t  r_mode;
  logic [IDX_W-1:0]   r_idx;
  logic [DCNT_W-1:0]  r_drain_cnt;
  logic               r_busy, r_calc_ready;
  logic [RES_W-1:0]   r_result, r_acc;
  logic [LANES-1:0][WIDTH-1:0] r_diff;
  logic               r_diff_vld;

  logic [CHUNKS-1:0][LANES-1:0][WIDTH-1:0] w_a_chunks, w_b_chunks;
  logic               w_accept, w_last_chunk, w_tree_vld;
  logic [TREE_W-1:0]  w_tree_data;

  assign w_a_chunks   = out_a;
  assign w_b_chunks   = out_b;
  assign w_accept     = start && (r_state == IDLE || r_state == DONE) && op_supported(op);
  assign w_last_chunk = (r_idx == IDX_W'(CHUNKS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_accept) w_state_nxt = RUN;
      RUN:        if (w_last_chunk) w_state_nxt = DRAIN;
      DRAIN:      if (r_drain_cnt == '0) w_state_nxt = DONE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // Drain counts down from TREE+1 so the final accumulate lands one edge before result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MODE_SUM;
      r_idx        <= '0;
      r_drain_cnt  <= '0;
      r_busy       <= 1'b0;
      r_calc_ready <= 1'b0;
      r_result     <= '0;
      r_acc        <= '0;
    end else begin
      if (w_accept) begin
        r_mode       <= op_mode(op);
        r_idx        <= '0;
        r_busy       <= 1'b1;
        r_calc_ready <= 1'b0;
      end
      if (r_state == RUN) begin
        r_idx <= r_idx + IDX_W'(1);
        if (w_last_chunk) r_drain_cnt <= DRAIN_LEN;
      end
      if (r_state == DRAIN) begin
        if (r_drain_cnt != '0) begin
          r_drain_cnt <= r_drain_cnt - DCNT_W'(1);
        end else begin
          r_result     <= r_acc;
          r_calc_ready <= 1'b1;
          r_busy       <= 1'b0;
        end
      end
      if (w_accept)
        r_acc <= '0;
`ifdef DIST_MAX_MODE_EN
      else if (w_tree_vld && r_mode == MODE_MAX)
        r_acc <= (RES_W'(w_tree_data) > r_acc) ? RES_W'(w_tree_data) : r_acc;
`endif
      else if (w_tree_vld)
        r_acc <= r_acc + RES_W'(w_tree_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff     <= '0;
      r_diff_vld <= 1'b0;
    end else begin
      r_diff_vld <= (r_state == RUN);
      for (int l = 0; l < LANES; l++) begin
        if (w_a_chunks[r_idx][l] > w_b_chunks[r_idx][l])
          r_diff[l] <= w_a_chunks[r_idx][l] - w_b_chunks[r_idx][l];
        else
          r_diff[l] <= w_b_chunks[r_idx][l] - w_a_chunks[r_idx][l];
      end
    end
  end

  reduce_tree_pipe #(
    .LANES (LANES),
    .IN_W  (WIDTH)
  ) u_tree (
    .clk    (clk),
    .rst    (rst),
    .i_mode (r_mode),
    .i_vld  (r_diff_vld),
    .i_data (r_diff),
    .o_vld  (w_tree_vld),
    .o_data (w_tree_data)
  );

  assign busy       = r_busy;
  assign calc_ready = r_calc_ready;
  assign result     = r_result;
  assign aux_result = AUX_W'(r_result);

endmodule

// File: tb/tb_vec_dist_pipe.sv
// Directed bench for vec_dist_pipe: a transaction-level model checked every cycle,
// plus hand-computed literal results and latencies.
module tb_vec_dist_pipe;

  localparam int WIDTH  = 8;
  localparam int LENGTH = 1024;
  localparam int LANES  = 64;
  localparam int RES_W  = WIDTH + $clog2(LENGTH);
  localparam int NBYTES = (RES_W + 7) / 8;
  localparam int LAT    = LENGTH / LANES + $clog2(LANES) + 2;

  logic clk = 1'b0;
  logic rst, start;
  logic [7:0] op;
  logic [LENGTH-1:0][WIDTH-1:0] out_a, out_b;
  logic busy, calc_ready;
  logic [RES_W-1:0] result;
  logic [NBYTES-1:0][7:0] aux_result;

  int checks = 0;
  int failures = 0;
  int lat;
  bit cmp_en = 1'b0;

  vec_dist_pipe #(.WIDTH(WIDTH), .LENGTH(LENGTH), .LANES(LANES)) dut (
    .clk        (clk),
    .rst        (rst),
    .out_a      (out_a),
    .out_b      (out_b),
    .op         (op),
    .start      (start),
    .busy       (busy),
    .calc_ready (calc_ready),
    .result     (result),
    .aux_result (aux_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic bit supported(input logic [7:0] o);
`ifdef DIST_MAX_MODE_EN
    return (o == 8'd103) || (o == 8'd104);
`else
    return o == 8'd103;
`endif
  endfunction

  function automatic longint model_dist(input logic [7:0] o);
    longint acc = 0;
    longint d;
    for (int i = 0; i < LENGTH; i++) begin
      d = (out_a[i] > out_b[i]) ? longint'(out_a[i]) - longint'(out_b[i])
                                : longint'(out_b[i]) - longint'(out_a[i]);
      if (o == 8'd104) acc = (d > acc) ? d : acc;
      else             acc = acc + d;
    end
    return acc;
  endfunction

  // Transaction model: an accepted request completes exactly LAT edges later.
  bit m_busy = 0, m_ready = 0;
  longint m_result = 0, m_pending = 0;
  int m_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0; m_ready = 0; m_result = 0; m_cnt = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0; m_ready = 1; m_result = m_pending;
      end
    end else if (start && supported(op)) begin
      m_busy = 1; m_ready = 0; m_cnt = LAT; m_pending = model_dist(op);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy", busy, m_busy);
      check("calc_ready", calc_ready, m_ready);
      check("result", result, m_result);
      for (int b = 0; b < NBYTES; b++)
        check($sformatf("aux_byte%0d", b), aux_result[b], (m_result >> (8 * b)) & 255);
    end
  end

  task automatic run_op(input logic [7:0] o, output int cycles);
    @(posedge clk); #2; start = 1'b1; op = o;
    @(posedge clk); #2; start = 1'b0;
    cycles = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (calc_ready) begin cycles = n; break; end
    end
  endtask

  task automatic pulse_ignored(input logic [7:0] o, input logic [63:0] keep);
    @(posedge clk); #2; start = 1'b1; op = o;
    @(posedge clk); #2; start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("ignored_busy", busy, 0);
    check("ignored_result", result, keep);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 8'd0; out_a = '0; out_b = '0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b0; cmp_en = 1'b1;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", calc_ready, 0);
    check("rst_result", result, 0);
    check("rst_aux", aux_result, 0);

    // 1: maximum per-element difference
    for (int i = 0; i < LENGTH; i++) begin out_a[i] = 8'hFF; out_b[i] = 8'h00; end
    run_op(8'd103, lat);
    check("t1_latency", lat, 24);
    check("t1_result", result, 261120);
    check("t1_busy", busy, 0);
    check("t1_aux0", aux_result[0], 8'h00);
    check("t1_aux1", aux_result[1], 8'hFC);
    check("t1_aux2", aux_result[2], 8'h03);

    // 2: mirrored ramps, then result must hold while idle
    for (int i = 0; i < LENGTH; i++) begin out_a[i] = 8'(i % 256); out_b[i] = 8'(255 - (i % 256)); end
    run_op(8'd103, lat);
    check("t2_latency", lat, 24);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("t2_hold", result, 131072);
    end

    // 3: unsupported opcode changes nothing
    pulse_ignored(8'h00, 131072);
    check("t3_ready", calc_ready, 1);

    // 4: restart during RUN and op change mid-run are ignored
    for (int i = 0; i < LENGTH; i++) begin out_a[i] = 8'(i % 256); out_b[i] = 8'h00; end
    @(posedge clk); #2; start = 1'b1; op = 8'd103;
    @(posedge clk); #2; start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (calc_ready) begin lat = n; break; end
      #1;
      if (n == 4) start = 1'b1;
      if (n == 5) begin start = 1'b0; op = 8'd0; end
    end
    check("t4_latency", lat, 24);
    check("t4_result", result, 130560);
    repeat (30) @(posedge clk);
    #1;
    check("t4_single", busy, 0);
    op = 8'd103;

    // 5: reset mid-run flushes everything
    for (int i = 0; i < LENGTH; i++) begin out_a[i] = 8'd3; out_b[i] = 8'd1; end
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (9) @(posedge clk);
    #2; rst = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_ready", calc_ready, 0);
    check("t5_rst_result", result, 0);
    #1; rst = 1'b0;
    run_op(8'd103, lat);
    check("t5_latency", lat, 24);
    check("t5_result", result, 2048);

    // 6: single differing element
    for (int i = 0; i < LENGTH; i++) begin out_a[i] = 8'((i * 7) % 256); out_b[i] = 8'((i * 7) % 256); end
    out_a[500] = 8'd200; out_b[500] = 8'd10;
`ifdef DIST_MAX_MODE_EN
    run_op(8'd104, lat);
    check("t6_max_latency", lat, 24);
    check("t6_max_result", result, 190);
`else
    pulse_ignored(8'd104, 2048);
`endif
    run_op(8'd103, lat);
    check("t6_latency", lat, 24);
    check("t6_result", result, 190);

`ifdef DIST_MAX_MODE_EN
    for (int i = 0; i < LENGTH; i++) begin out_a[i] = 8'(i % 256); out_b[i] = 8'h00; end
    run_op(8'd104, lat);
    check("t7_max_result", result, 255);
`endif

    repeat (3) @(posedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
